// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - WIDTH_DEFAULT : default operand/result width
//   - state_e       : FSM state encoding (IDLE / SHIFT / DONE, 2'd3 illegal)
//   - sub_ovf()     : two's-complement overflow rule for a - b
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Overflow of a - b: operands of differing sign and a result whose sign
  // differs from the minuend.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor computing x - y - bin. Its port list
// mirrors the full-adder cell (x, y, carry-in -> sum, carry-out).
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: computes a - b one bit per clock, LSB
// first, through a single full_subtractor cell with a registered borrow.
// Start/done handshake; results hold until the next completed operation.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request a subtraction, accepted only while ready=1
//   a, b  : minuend / subtrahend, captured on the accepted start edge
//   ready : high while idle
//   done  : one-cycle pulse when diff/bout/ovf are updated
//   diff  : a - b modulo 2^WIDTH
//   bout  : unsigned borrow (a < b)
//   ovf   : two's-complement overflow of a - b
// ----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Only WIDTH-1 partial bits are stored; the last bit joins them directly
  // on the final edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             cell_d_s;
  logic             cell_bout_s;
  logic [WIDTH-1:0] res_cat_s;

  full_subtractor u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (brw_q),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // Next-state, datapath shifting and result loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    brw_d     = brw_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    res_cat_s = {cell_d_s, res_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          res_d   = {(WIDTH-1){1'b0}};
          brw_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        brw_d = cell_bout_s;
        res_d = res_cat_s[WIDTH-1:1];
        if (cnt_q == CNT_LAST) begin
          // On the last bit the operand LSBs are the original MSBs, so the
          // overflow rule needs no separately captured sign bits.
          state_d = DONE;
          diff_d  = res_cat_s;
          bout_d  = cell_bout_s;
          ovf_d   = sub_ovf(a_q[0], b_q[0], cell_d_s);
        end else begin
          state_d = SHIFT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        // Illegal encoding recovers to IDLE.
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {(WIDTH-1){1'b0}};
      brw_q   <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;

endmodule
